tl_ul_source_arbiter: RTL and testbench
=======================================

Name: tl_ul_source_arbiter

Overview:
- Shares one TileLink-UL master port (A out / D in, 32-bit data, 8-bit source) among NUM_REQ client ports, each with a 6-bit source.
- A channel: round-robin arbitration. Each winner's source is widened to {client_source[5:0], client_idx[1:0]}.
- D channel: responses are steered back by d_source[1:0], and d_source[7:2] is returned to the client.
- Multi-beat Put bursts hold the grant until their last beat.

Parameters:
NUM_REQ, 4, number of clients, 1..4 (index occupies source bits [1:0])
SIZE_W, 3, width of a_size/d_size (log2 bytes, max 2^(2^SIZE_W-1))

Ports:
clock  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
c_a_valid  in  NUM_REQ  per-client A valid
c_a_ready  out  NUM_REQ  per-client A ready
c_a_opcode  in  3*NUM_REQ  A opcode, client i at [3i+:3]
c_a_param  in  3*NUM_REQ  A param
c_a_size  in  SIZE_W*NUM_REQ  A size
c_a_source  in  6*NUM_REQ  A source
c_a_address  in  32*NUM_REQ  A address
c_a_mask  in  4*NUM_REQ  A mask
c_a_data  in  32*NUM_REQ  A data
c_d_valid  out  NUM_REQ  per-client D valid
c_d_ready  in  NUM_REQ  per-client D ready
c_d_source  out  6  returned source, shared bus
m_a_valid  out  1  master A valid
m_a_ready  in  1  master A ready
m_a_opcode/param/size/address/mask/data  out  3/3/SIZE_W/32/4/32  muxed A fields
m_a_source  out  8  {client source, client index}
m_a_grant  out  2  current winner index, debug/perf
m_d_valid  in  1  master D valid
m_d_ready  out  1  master D ready
m_d_source  in  8  D source
(D opcode/param/size/denied/data/corrupt fan out to clients unregistered; outside this block.)

Behaviour:
- Reset: asserting reset_n low asynchronously sets state=IDLE, rr_ptr=0, beats_left=0, hold_idx=0.
- While reset_n is low: m_a_valid=0, c_a_ready=0, m_d_ready=0, c_d_valid=0, m_a_grant=0.
- States:
  - IDLE: winner = first valid client at or after rr_ptr, modulo NUM_REQ, chosen combinationally with zero latency.
  - HOLD: the first beat has been presented but not accepted. The grant is frozen to hold_idx.
  - BURST: remaining data beats. The grant is frozen to hold_idx.
- A muxing:
  - m_a_valid = c_a_valid[grant].
  - c_a_ready[i] = m_a_ready & (i==grant) & c_a_valid[i]. All other clients see ready=0.
- Beats per message:
  - Opcode 0 (PutFull) or 1 (PutPartial) with size>2: 2^(size-2) beats.
  - Everything else: 1 beat.
  - beats_left is a 2^SIZE_W-bit-safe counter.
- Transitions:
  - IDLE, valid & !ready -> HOLD, hold_idx=winner.
  - IDLE or HOLD, fire & single-beat -> IDLE, rr_ptr = grant+1 mod NUM_REQ.
  - IDLE or HOLD, fire & multi-beat -> BURST, beats_left = beats-1, hold_idx = grant.
  - BURST, fire: decrement beats_left. If it was 1 -> IDLE, rr_ptr = hold_idx+1.
- In HOLD, a newly valid higher-priority client never changes the grant. The A output stays stable until it fires.
- rr_ptr advances only on message completion, never on partial bursts.
- A client dropping valid mid-burst is a protocol violation: outputs simply follow its valid, and the state is held.
- D routing is combinational:
  - idx = m_d_source[1:0].
  - c_d_valid[i] = m_d_valid & (idx==i).
  - m_d_ready = c_d_ready[idx].
  - c_d_source = m_d_source[7:2].
  - idx >= NUM_REQ: m_d_ready=1 (drain) and no c_d_valid is raised.
- A and D are independent. Simultaneous A fire and D fire on the same client is legal.
- NUM_REQ=1: the grant is constant 0 and m_a_source[1:0]=0.

Decomposition:
- Package tl_ul_pkg:
  - Opcode constants: PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACK=0, ACK_DATA=1.
  - Field widths: SOURCE_W=6, IDX_W=2, DATA_W=32.
  - Function beats_of(opcode,size).
  - Arbiter state enum {IDLE,HOLD,BURST}.
- One sub-module, rr_pick: combinational first-set-at-or-after-pointer picker (NUM_REQ, valid, ptr -> idx, any). Reusable by other arbiters.

Test Plan:
1. Round-robin fairness: NUM_REQ=4, all four clients issue Get size=2 continuously, m_a_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; m_a_source[1:0] matches the grant; client source 0x2A appears as m_a_source=0xA8|idx.
2. Burst lock: client 1 issues PutFull size=4 (4 beats) while client 2 is valid -> m_a_grant=1 for exactly 4 fires; client 2 is granted on the following cycle; rr_ptr=2 after the burst.
3. Stall stability: client 3 valid, m_a_ready=0 for 5 cycles, client 0 raises valid at cycle 2 -> grant stays 3 and all m_a fields are constant until the fire; client 0 is served next.
4. D routing: m_d_valid with m_d_source=0x9E -> only c_d_valid[2]=1 and c_d_source=0x27; with c_d_ready[2]=0, m_d_ready=0; raising c_d_ready[2] completes the beat. m_d_source=0x03 with NUM_REQ=3 -> m_d_ready=1 and all c_d_valid=0.
5. Reset mid-burst: drop reset_n asynchronously at beat 2 of a 4-beat Put -> outputs go to reset values immediately (no clock edge needed); after release, state=IDLE, rr_ptr=0, and client 0 wins first.
6. Simultaneous A and D: A fire of a client-1 single-beat Get in the same cycle as a D response to client 1 -> both complete in one cycle; the next A grant goes to client 2.

Source files
------------

// File: rtl/tl_ul_source_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_pkg
// Description : Shared TileLink-UL constants, field widths, arbiter state
//               encoding and the beat-count helper for the source arbiter.
// Contents    : opcode constants, SOURCE_W/IDX_W/DATA_W, arb_state_e,
//               beats_of(opcode, size)
// Revision    : 1.0 - initial release
// ============================================================================
package tl_ul_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  // D-channel opcodes
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  localparam int SOURCE_W = 6;
  localparam int IDX_W    = 2;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BURST = 2'd2
  } arb_state_e;

  // Puts larger than one 32-bit word carry one data beat per word; every
  // other message is a single beat.
  function automatic logic [31:0] beats_of(input logic [2:0] opcode,
                                           input logic [7:0] size);
    logic [31:0] beats;
    beats = 32'd1;
    if ((opcode == PUT_FULL || opcode == PUT_PARTIAL) && size > 8'd2)
      beats = 32'd1 << (size - 8'd2);
    return beats;
  endfunction

endpackage : tl_ul_pkg
`default_nettype wire

// File: rtl/tl_ul_source_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of valid at or after ptr, wrapping modulo NUM_REQ.
// Ports       : valid [NUM_REQ] requests, ptr [2] start position,
//               idx [2] chosen index (ptr when none), any [1] any request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import tl_ul_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [3:0] w_valid_pad;
  logic [2:0] w_pos;

  // Scan from the farthest offset down to offset 0 so the nearest request
  // to ptr is the last (winning) assignment.
  always_comb begin
    w_valid_pad                = '0;
    w_valid_pad[NUM_REQ-1:0]   = valid;
    w_pos                      = '0;
    idx                        = ptr;
    any                        = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = {1'b0, ptr} + 3'(k);
      if (w_pos >= 3'(NUM_REQ))
        w_pos = w_pos - 3'(NUM_REQ);
      if (w_valid_pad[w_pos[1:0]]) begin
        idx = w_pos[1:0];
        any = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/tl_ul_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_source_arbiter
// Description : Shares one TileLink-UL master port among NUM_REQ clients.
//               A channel is round-robin arbitrated with the client index
//               appended to the source; multi-beat Puts keep the grant.
//               D channel is steered back by d_source[1:0].
// Ports       : clock/reset_n; c_a_* client A (packed, client i at slot i);
//               c_d_valid/c_d_ready/c_d_source client D; m_a_* master A;
//               m_a_grant current winner; m_d_valid/m_d_ready/m_d_source.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_source_arbiter
  import tl_ul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SIZE_W  = 3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           c_a_valid,
  output logic [NUM_REQ-1:0]           c_a_ready,
  input  logic [3*NUM_REQ-1:0]         c_a_opcode,
  input  logic [3*NUM_REQ-1:0]         c_a_param,
  input  logic [SIZE_W*NUM_REQ-1:0]    c_a_size,
  input  logic [SOURCE_W*NUM_REQ-1:0]  c_a_source,
  input  logic [32*NUM_REQ-1:0]        c_a_address,
  input  logic [4*NUM_REQ-1:0]         c_a_mask,
  input  logic [DATA_W*NUM_REQ-1:0]    c_a_data,
  output logic [NUM_REQ-1:0]           c_d_valid,
  input  logic [NUM_REQ-1:0]           c_d_ready,
  output logic [SOURCE_W-1:0]          c_d_source,
  output logic                         m_a_valid,
  input  logic                         m_a_ready,
  output logic [2:0]                   m_a_opcode,
  output logic [2:0]                   m_a_param,
  output logic [SIZE_W-1:0]            m_a_size,
  output logic [SOURCE_W+IDX_W-1:0]    m_a_source,
  output logic [31:0]                  m_a_address,
  output logic [3:0]                   m_a_mask,
  output logic [DATA_W-1:0]            m_a_data,
  output logic [IDX_W-1:0]             m_a_grant,
  input  logic                         m_d_valid,
  output logic                         m_d_ready,
  input  logic [SOURCE_W+IDX_W-1:0]    m_d_source
);

  localparam int BEATS_W = 2 ** SIZE_W;

  arb_state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr, w_rr_nxt;
  logic [IDX_W-1:0]     r_hold_idx, w_hold_nxt;
  logic [BEATS_W-1:0]   r_beats_left, w_beats_nxt;

  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic [IDX_W-1:0]     w_grant;
  logic                 w_valid_sel;
  logic                 w_valid_mux;
  logic [2:0]           w_opcode;
  logic [2:0]           w_param;
  logic [SIZE_W-1:0]    w_size;
  logic [SOURCE_W-1:0]  w_source;
  logic [31:0]          w_address;
  logic [3:0]           w_mask;
  logic [DATA_W-1:0]    w_data;
  logic [BEATS_W-1:0]   w_beats;
  logic                 w_fire;
  logic [IDX_W-1:0]     w_ptr_after;
  logic [IDX_W-1:0]     w_d_idx;
  logic                 w_d_in_range;
  logic [3:0]           w_d_ready_pad;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
    logic [IDX_W-1:0] nxt;
    nxt = cur + 1'b1;
    if ({1'b0, cur} >= 3'(NUM_REQ - 1))
      nxt = '0;
    return nxt;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .valid (c_a_valid),
    .ptr   (r_rr_ptr),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  // The picker only steers the grant while idle; once a message has been
  // presented the grant is frozen so the A fields cannot change under it.
  assign w_grant = (r_state == IDLE) ? w_pick_idx : r_hold_idx;

  always_comb begin
    w_valid_mux = 1'b0;
    w_opcode    = '0;
    w_param     = '0;
    w_size      = '0;
    w_source    = '0;
    w_address   = '0;
    w_mask      = '0;
    w_data      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == IDX_W'(i)) begin
        w_valid_mux = c_a_valid[i];
        w_opcode    = c_a_opcode[3*i +: 3];
        w_param     = c_a_param[3*i +: 3];
        w_size      = c_a_size[SIZE_W*i +: SIZE_W];
        w_source    = c_a_source[SOURCE_W*i +: SOURCE_W];
        w_address   = c_a_address[32*i +: 32];
        w_mask      = c_a_mask[4*i +: 4];
        w_data      = c_a_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // In IDLE the grant is the picker's choice, so "any" equals the muxed valid.
  assign w_valid_sel = (r_state == IDLE) ? w_pick_any : w_valid_mux;

  assign m_a_valid   = reset_n & w_valid_sel;
  assign m_a_opcode  = w_opcode;
  assign m_a_param   = w_param;
  assign m_a_size    = w_size;
  assign m_a_source  = {w_source, w_grant};
  assign m_a_address = w_address;
  assign m_a_mask    = w_mask;
  assign m_a_data    = w_data;
  assign m_a_grant   = reset_n ? w_grant : '0;

  assign w_fire      = m_a_valid & m_a_ready;
  assign w_beats     = BEATS_W'(beats_of(w_opcode, 8'(w_size)));
  assign w_ptr_after = next_ptr(w_grant);

  // D routing: index in the low source bits, anything out of range is drained.
  assign w_d_idx      = m_d_source[IDX_W-1:0];
  assign w_d_in_range = ({1'b0, w_d_idx} < 3'(NUM_REQ));
  assign c_d_source   = m_d_source[SOURCE_W+IDX_W-1:IDX_W];

  always_comb begin
    w_d_ready_pad              = '0;
    w_d_ready_pad[NUM_REQ-1:0] = c_d_ready;
  end

  assign m_d_ready = reset_n & (w_d_in_range ? w_d_ready_pad[w_d_idx] : 1'b1);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_client
      assign c_a_ready[gi] = reset_n & m_a_ready & (w_grant == IDX_W'(gi))
                             & c_a_valid[gi];
      assign c_d_valid[gi] = reset_n & m_d_valid & (w_d_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_hold_nxt  = r_hold_idx;
    w_beats_nxt = r_beats_left;
    case (r_state)
      IDLE, HOLD: begin
        if (w_valid_sel) begin
          if (m_a_ready) begin
            if (w_beats > BEATS_W'(1)) begin
              w_state_nxt = BURST;
              w_beats_nxt = w_beats - BEATS_W'(1);
              w_hold_nxt  = w_grant;
            end else begin
              w_state_nxt = IDLE;
              w_rr_nxt    = w_ptr_after;
            end
          end else begin
            w_state_nxt = HOLD;
            w_hold_nxt  = w_grant;
          end
        end
      end
      BURST: begin
        if (w_fire) begin
          if (r_beats_left == BEATS_W'(1)) begin
            w_state_nxt = IDLE;
            w_beats_nxt = '0;
            w_rr_nxt    = w_ptr_after;
          end else begin
            w_beats_nxt = r_beats_left - BEATS_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_hold_idx   <= '0;
      r_beats_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_hold_idx   <= w_hold_nxt;
      r_beats_left <= w_beats_nxt;
    end
  end

endmodule : tl_ul_source_arbiter
`default_nettype wire

// File: tb/tb_tl_ul_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_ul_source_arbiter
// Description : Directed self-checking bench for tl_ul_source_arbiter.
//               Main instance has four clients; a second three-client
//               instance covers out-of-range D draining.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_ul_source_arbiter;
  import tl_ul_pkg::*;

  logic         clock;
  logic         reset_n;
  logic [3:0]   c_a_valid, c_a_ready;
  logic [11:0]  c_a_opcode, c_a_param, c_a_size;
  logic [23:0]  c_a_source;
  logic [127:0] c_a_address, c_a_data;
  logic [15:0]  c_a_mask;
  logic [3:0]   c_d_valid, c_d_ready;
  logic [5:0]   c_d_source;
  logic         m_a_valid, m_a_ready;
  logic [2:0]   m_a_opcode, m_a_param, m_a_size;
  logic [7:0]   m_a_source;
  logic [31:0]  m_a_address, m_a_data;
  logic [3:0]   m_a_mask;
  logic [1:0]   m_a_grant;
  logic         m_d_valid, m_d_ready;
  logic [7:0]   m_d_source;

  logic [2:0]   d3_c_a_valid, d3_c_a_ready, d3_c_d_valid, d3_c_d_ready;
  logic [8:0]   d3_c_a_opcode, d3_c_a_param, d3_c_a_size;
  logic [17:0]  d3_c_a_source;
  logic [95:0]  d3_c_a_address, d3_c_a_data;
  logic [11:0]  d3_c_a_mask;
  logic [5:0]   d3_c_d_source;
  logic         d3_m_a_valid, d3_m_a_ready;
  logic [2:0]   d3_m_a_opcode, d3_m_a_param, d3_m_a_size;
  logic [7:0]   d3_m_a_source;
  logic [31:0]  d3_m_a_address, d3_m_a_data;
  logic [3:0]   d3_m_a_mask;
  logic [1:0]   d3_m_a_grant;
  logic         d3_m_d_valid, d3_m_d_ready;
  logic [7:0]   d3_m_d_source;

  int n_assert = 0;
  int n_fail   = 0;

  tl_ul_source_arbiter #(.NUM_REQ(4), .SIZE_W(3)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .c_a_valid(c_a_valid), .c_a_ready(c_a_ready), .c_a_opcode(c_a_opcode),
    .c_a_param(c_a_param), .c_a_size(c_a_size), .c_a_source(c_a_source),
    .c_a_address(c_a_address), .c_a_mask(c_a_mask), .c_a_data(c_a_data),
    .c_d_valid(c_d_valid), .c_d_ready(c_d_ready), .c_d_source(c_d_source),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
    .m_a_param(m_a_param), .m_a_size(m_a_size), .m_a_source(m_a_source),
    .m_a_address(m_a_address), .m_a_mask(m_a_mask), .m_a_data(m_a_data),
    .m_a_grant(m_a_grant), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .m_d_source(m_d_source)
  );

  tl_ul_source_arbiter #(.NUM_REQ(3), .SIZE_W(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .c_a_valid(d3_c_a_valid), .c_a_ready(d3_c_a_ready),
    .c_a_opcode(d3_c_a_opcode), .c_a_param(d3_c_a_param),
    .c_a_size(d3_c_a_size), .c_a_source(d3_c_a_source),
    .c_a_address(d3_c_a_address), .c_a_mask(d3_c_a_mask),
    .c_a_data(d3_c_a_data), .c_d_valid(d3_c_d_valid),
    .c_d_ready(d3_c_d_ready), .c_d_source(d3_c_d_source),
    .m_a_valid(d3_m_a_valid), .m_a_ready(d3_m_a_ready),
    .m_a_opcode(d3_m_a_opcode), .m_a_param(d3_m_a_param),
    .m_a_size(d3_m_a_size), .m_a_source(d3_m_a_source),
    .m_a_address(d3_m_a_address), .m_a_mask(d3_m_a_mask),
    .m_a_data(d3_m_a_data), .m_a_grant(d3_m_a_grant),
    .m_d_valid(d3_m_d_valid), .m_d_ready(d3_m_d_ready),
    .m_d_source(d3_m_d_source)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_client(input int i, input logic v, input logic [2:0] op,
                            input logic [2:0] sz, input logic [5:0] src,
                            input logic [31:0] addr, input logic [31:0] dat);
    c_a_valid[i]          = v;
    c_a_opcode[3*i +: 3]  = op;
    c_a_param[3*i +: 3]   = 3'd0;
    c_a_size[3*i +: 3]    = sz;
    c_a_source[6*i +: 6]  = src;
    c_a_address[32*i +: 32] = addr;
    c_a_mask[4*i +: 4]    = 4'hF;
    c_a_data[32*i +: 32]  = dat;
  endtask

  initial begin
    reset_n     = 1'b0;
    c_a_valid   = 4'hF;
    c_a_opcode  = '0; c_a_param = '0; c_a_size = '0; c_a_source = '0;
    c_a_address = '0; c_a_mask = '0; c_a_data = '0;
    c_d_ready   = 4'hF;
    m_a_ready   = 1'b1;
    m_d_valid   = 1'b1;
    m_d_source  = 8'h01;
    d3_c_a_valid = '0; d3_c_a_opcode = '0; d3_c_a_param = '0;
    d3_c_a_size = '0; d3_c_a_source = '0; d3_c_a_address = '0;
    d3_c_a_mask = '0; d3_c_a_data = '0; d3_c_d_ready = '0;
    d3_m_a_ready = 1'b0; d3_m_d_valid = 1'b0; d3_m_d_source = '0;

    // Reset: outputs forced quiet even with every input active
    #7;
    chk("rst_m_a_valid", 64'(m_a_valid), 64'h0);
    chk("rst_c_a_ready", 64'(c_a_ready), 64'h0);
    chk("rst_m_d_ready", 64'(m_d_ready), 64'h0);
    chk("rst_c_d_valid", 64'(c_d_valid), 64'h0);
    chk("rst_grant",     64'(m_a_grant), 64'h0);
    c_a_valid = '0; m_d_valid = 1'b0; c_d_ready = '0; m_a_ready = 1'b0;
    #5 reset_n = 1'b1;

    // 1: round-robin over four continuous Gets, source 0x2A -> 0xA8|idx
    tick();
    for (int i = 0; i < 4; i++)
      set_client(i, 1'b1, GET, 3'd2, 6'h2A, 32'h1000_0000 + 32'(i), 32'(i));
    m_a_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("rr_grant",  64'(m_a_grant),  64'(k % 4));
      chk("rr_source", 64'(m_a_source), 64'(8'hA8 | 8'(k % 4)));
      chk("rr_ready",  64'(c_a_ready),  64'(4'b0001 << (k % 4)));
      tick();
    end
    c_a_valid = '0;

    // 2: client 1 4-beat PutFull holds grant while client 2 waits
    set_client(1, 1'b1, PUT_FULL, 3'd4, 6'h11, 32'h2000_0010, 32'hAAAA_0001);
    set_client(2, 1'b1, GET,      3'd2, 6'h22, 32'h2000_0020, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("burst_grant",  64'(m_a_grant),  64'h1);
      chk("burst_opcode", 64'(m_a_opcode), 64'h0);
      tick();
    end
    #2;
    chk("post_burst_grant",  64'(m_a_grant),      64'h2);
    chk("post_burst_rr_ptr", 64'(u_dut.r_rr_ptr), 64'h2);
    chk("post_burst_source", 64'(m_a_source),     64'h8A);
    tick();
    c_a_valid = '0;

    // 3: client 3 stalled; client 0 raises valid mid-stall
    set_client(3, 1'b1, GET, 3'd2, 6'h15, 32'h3000_0030, 32'hDEAD_0003);
    m_a_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2)
        set_client(0, 1'b1, GET, 3'd2, 6'h01, 32'h1000_0000, 32'h0);
      #2;
      chk("stall_grant",   64'(m_a_grant),   64'h3);
      chk("stall_address", 64'(m_a_address), 64'h3000_0030);
      chk("stall_source",  64'(m_a_source),  64'h57);
      chk("stall_ready",   64'(c_a_ready),   64'h0);
      if (k > 0)
        chk("stall_state", 64'(u_dut.r_state), 64'(HOLD));
      tick();
    end
    m_a_ready = 1'b1;
    #2;
    chk("stall_fire_ready", 64'(c_a_ready), 64'b1000);
    tick();
    c_a_valid[3] = 1'b0;
    #2;
    chk("after_stall_grant",  64'(m_a_grant),  64'h0);
    chk("after_stall_source", 64'(m_a_source), 64'h04);
    tick();
    c_a_valid = '0;

    // 4: D routing, back-pressure, and drain of an out-of-range index
    m_d_valid  = 1'b1;
    m_d_source = 8'h9E;
    c_d_ready  = 4'b1011;
    #2;
    chk("d_valid",   64'(c_d_valid),  64'b0100);
    chk("d_source",  64'(c_d_source), 64'h27);
    chk("d_ready_0", 64'(m_d_ready),  64'h0);
    c_d_ready = 4'b0100;
    #2;
    chk("d_ready_1", 64'(m_d_ready),  64'h1);
    tick();
    m_d_valid = 1'b0;
    d3_m_d_valid  = 1'b1;
    d3_m_d_source = 8'h03;
    #2;
    chk("d3_drain_ready", 64'(d3_m_d_ready), 64'h1);
    chk("d3_drain_valid", 64'(d3_c_d_valid), 64'h0);
    d3_m_d_source = 8'h06;
    #2;
    chk("d3_idx2_valid", 64'(d3_c_d_valid), 64'b100);
    chk("d3_idx2_ready", 64'(d3_m_d_ready), 64'h0);
    d3_m_d_valid = 1'b0;

    // 6: same-cycle A fire and D response on client 1
    tick();
    set_client(1, 1'b1, GET, 3'd2, 6'h05, 32'h4000_0010, 32'h0);
    set_client(2, 1'b1, GET, 3'd2, 6'h06, 32'h4000_0020, 32'h0);
    m_d_valid  = 1'b1;
    m_d_source = 8'h15;
    c_d_ready  = 4'b0010;
    #2;
    chk("ad_grant",    64'(m_a_grant),  64'h1);
    chk("ad_a_ready",  64'(c_a_ready),  64'b0010);
    chk("ad_d_valid",  64'(c_d_valid),  64'b0010);
    chk("ad_d_ready",  64'(m_d_ready),  64'h1);
    chk("ad_d_source", 64'(c_d_source), 64'h05);
    tick();
    c_a_valid[1] = 1'b0;
    m_d_valid    = 1'b0;
    #2;
    chk("ad_next_grant", 64'(m_a_grant), 64'h2);
    tick();
    c_a_valid = '0;

    // 5: asynchronous reset during beat 2 of a 4-beat Put (rr_ptr is 3)
    set_client(0, 1'b1, PUT_FULL, 3'd4, 6'h3F, 32'h0000_0100, 32'h5555_0000);
    m_d_valid  = 1'b1;
    m_d_source = 8'h00;
    c_d_ready  = 4'b0001;
    #2;
    chk("rb_beat1_grant", 64'(m_a_grant), 64'h0);
    tick();
    #2;
    chk("rb_beat2_state",  64'(u_dut.r_state),  64'(BURST));
    chk("rb_beat2_rr_ptr", 64'(u_dut.r_rr_ptr), 64'h3);
    chk("rb_beat2_valid",  64'(m_a_valid),      64'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("rb_m_a_valid", 64'(m_a_valid),      64'h0);
    chk("rb_c_a_ready", 64'(c_a_ready),      64'h0);
    chk("rb_grant",     64'(m_a_grant),      64'h0);
    chk("rb_m_d_ready", 64'(m_d_ready),      64'h0);
    chk("rb_c_d_valid", 64'(c_d_valid),      64'h0);
    chk("rb_state",     64'(u_dut.r_state),  64'(IDLE));
    chk("rb_rr_ptr",    64'(u_dut.r_rr_ptr), 64'h0);
    #2 reset_n = 1'b1;
    m_d_valid = 1'b0;
    set_client(0, 1'b1, GET, 3'd2, 6'h01, 32'h0000_0200, 32'h0);
    set_client(3, 1'b1, GET, 3'd2, 6'h33, 32'h0000_0300, 32'h0);
    #1;
    chk("rel_grant",  64'(m_a_grant),  64'h0);
    chk("rel_opcode", 64'(m_a_opcode), 64'(GET));
    tick();
    chk("rel_state_after_fire", 64'(u_dut.r_state), 64'(IDLE));
    chk("rel_next_grant",       64'(m_a_grant),     64'h3);
    c_a_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule : tb_tl_ul_source_arbiter
`default_nettype wire
